// File: rtl/uart_pkg.sv
// Shared UART types: receive FSM state encoding and the oversample vote-tick helpers.
// Latency: none (types and constant functions only); backpressure: not applicable.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAITIDLE
    } rx_state_t;

    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_DATA_BITS  = 8;

    // Three samples straddle mid-bit; the vote becomes valid on the last of them.
    function automatic int sampleTickA(input int oversample);
        return oversample / 2 - 1;
    endfunction

    function automatic int sampleTickB(input int oversample);
        return oversample / 2;
    endfunction

    function automatic int voteTick(input int oversample);
        return oversample / 2 + 1;
    endfunction

endpackage

// File: rtl/uart_rx_oversample_if.sv
// Receive-side bundle: baud tick and raw line in, received byte and status pulses out.
// Latency: wires only; backpressure: none, the consumer must take done/err every cycle.
interface uart_rx_oversample_if;
    logic       en;
    logic       in;
    logic [7:0] data;
    logic       done;
    logic       err;
    logic       busy;

    modport master (input en, input in, output data, output done, output err, output busy);
    modport slave  (output en, output in, input data, input done, input err, input busy);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable reset value.
// Latency: 2 clk; backpressure: none.
module sync_2ff #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= ResetVal;
            q    <= ResetVal;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: majority-voted bits, glitch and framing-error rejection.
// Latency: done 2 + Oversample*(1+DataBits) + Oversample/2+1 ticks after the start edge; no backpressure.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int Oversample = DEFAULT_OVERSAMPLE,
    parameter int DataBits   = DEFAULT_DATA_BITS
) (
    input logic                    clk,
    input logic                    reset,
    uart_rx_oversample_if.master   rxIf
);
    localparam int TW = $clog2(Oversample);
    localparam logic [TW-1:0] TICK_A    = TW'(sampleTickA(Oversample));
    localparam logic [TW-1:0] TICK_B    = TW'(sampleTickB(Oversample));
    localparam logic [TW-1:0] TICK_VOTE = TW'(voteTick(Oversample));
    localparam logic [TW-1:0] TICK_LAST = TW'(Oversample - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DataBits - 1);

    rx_state_t             state;
    rx_state_t             stateNext;
    logic [TW-1:0]         tick;
    logic [2:0]            bitIdx;
    logic                  sampA;
    logic                  sampB;
    logic [DataBits-1:0]   shiftReg;
    logic [7:0]            dataReg;
    logic                  doneReg;
    logic                  errReg;
    logic                  busyReg;
    logic                  inS;
    logic                  en;
    logic                  vote;
    logic                  atVote;
    logic                  atLast;

    assign en = rxIf.en;

    sync_2ff #(.ResetVal(1'b1)) inSync (
        .clk   (clk),
        .reset (reset),
        .d     (rxIf.in),
        .q     (inS)
    );

    always_comb begin
        vote      = (sampA & sampB) | (sampA & inS) | (sampB & inS);
        atVote    = en && (tick == TICK_VOTE);
        atLast    = en && (tick == TICK_LAST);
        stateNext = state;
        case (state)
            IDLE:     if (en && !inS) stateNext = START;
            START:    if (atVote && vote) stateNext = IDLE;
                      else if (atLast) stateNext = DATA;
            DATA:     if (atLast && bitIdx == BIT_LAST) stateNext = STOP;
            STOP:     if (atVote) stateNext = vote ? IDLE : WAITIDLE;
            WAITIDLE: if (en && inS) stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tick     <= '0;
            bitIdx   <= '0;
            sampA    <= 1'b1;
            sampB    <= 1'b1;
            shiftReg <= '0;
            dataReg  <= '0;
            doneReg  <= 1'b0;
            errReg   <= 1'b0;
            busyReg  <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            errReg  <= 1'b0;
            if (en) begin
                state   <= stateNext;
                busyReg <= (stateNext != IDLE);
                if (tick == TICK_A) sampA <= inS;
                if (tick == TICK_B) sampB <= inS;

                // Detecting tick counts as tick 0, so entering START lands on tick 1.
                case (stateNext)
                    IDLE, WAITIDLE: tick <= '0;
                    default:        tick <= (tick == TICK_LAST) ? '0 : tick + TW'(1);
                endcase

                if (state == START)
                    bitIdx <= '0;
                else if (state == DATA && tick == TICK_LAST && bitIdx != BIT_LAST)
                    bitIdx <= bitIdx + 3'd1;

                if (state == DATA && tick == TICK_VOTE)
                    shiftReg <= {vote, shiftReg[DataBits-1:1]};

                if (state == STOP && tick == TICK_VOTE) begin
                    if (vote) begin
                        dataReg <= 8'(shiftReg);
                        doneReg <= 1'b1;
                    end else begin
                        errReg <= 1'b1;
                    end
                end
            end
        end
    end

    assign rxIf.data = dataReg;
    assign rxIf.done = doneReg;
    assign rxIf.err  = errReg;
    assign rxIf.busy = busyReg;
endmodule
